// File: rtl/soc_bram_arb_if.sv
// Request/response bus shared by all channels of soc_bram_arb.
// Per-channel fields are packed side by side; channel i occupies slice i.
interface soc_bram_arb_if #(
  parameter int N_CH = 2,
  parameter int AW   = 8,
  parameter int DW   = 32
) ();
  localparam int NB = DW / 8;

  logic [N_CH-1:0]    req_valid;
  logic [N_CH-1:0]    req_ready;
  logic [N_CH*AW-1:0] req_addr;
  logic [N_CH*DW-1:0] req_wdata;
  logic [N_CH*NB-1:0] req_wmsk;   // 1 = lane not written
  logic [N_CH-1:0]    req_we;
  logic [N_CH-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;

  // Requestor side
  modport master (
    output req_valid, req_addr, req_wdata, req_wmsk, req_we,
    input  req_ready, rsp_valid, rsp_rdata
  );

  // Memory/arbiter side
  modport slave (
    input  req_valid, req_addr, req_wdata, req_wmsk, req_we,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/soc_bram_arb.sv
// N-channel round-robin arbitrated single-port block RAM.
// One access per cycle, read-first on writes, byte masks active-low,
// optional output register stage (read latency 1 or 2).
module soc_bram_arb #(
  parameter int SIZE      = 256,
  parameter int AW        = $clog2(SIZE),
  parameter int DW        = 32,
  parameter int N_CH      = 2,
  parameter int OUT_REG   = 0,
  parameter     INIT_FILE = ""
) (
  input  logic           clk,
  input  logic           rst_n,
  soc_bram_arb_if.slave  bus
);
  localparam int NB = DW / 8;
  // Channel index width; kept at least 1 so N_CH=1 still has a legal vector.
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  // Unpacked per-channel request fields
  logic [AW-1:0] ch_addr  [N_CH];
  logic [DW-1:0] ch_wdata [N_CH];
  logic [NB-1:0] ch_wmsk  [N_CH];

  logic [CW-1:0]   ptr_reg;      // channel searched first this cycle
  logic [CW-1:0]   grant_idx;
  logic            grant_any;
  logic [N_CH-1:0] grant_oh;

  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [NB-1:0] sel_wmsk;
  logic          sel_we;
  logic          sel_in_range;

  logic [DW-1:0]   mem [SIZE];
  logic [DW-1:0]   mem_rdata_reg;
  logic [N_CH-1:0] s1_oh_reg;    // channel whose data is in mem_rdata_reg
  logic            seen_reg;     // mem_rdata_reg holds data captured since reset

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign ch_addr[gi]  = bus.req_addr[gi*AW +: AW];
      assign ch_wdata[gi] = bus.req_wdata[gi*DW +: DW];
      assign ch_wmsk[gi]  = bus.req_wmsk[gi*NB +: NB];
      assign grant_oh[gi] = grant_any && (grant_idx == CW'(gi));
    end
  endgenerate

  // Ready never looks at the response pipeline: no stalls.
  assign bus.req_ready = grant_oh;

  // Round-robin search starting at ptr_reg; nothing is granted while in reset.
  always_comb begin
    int          c;
    logic [CW-1:0] c_idx;
    grant_any = 1'b0;
    grant_idx = '0;
    c         = 0;
    c_idx     = '0;
    for (int k = 0; k < N_CH; k++) begin
      c = int'(ptr_reg) + k;
      if (c >= N_CH) c = c - N_CH;
      c_idx = CW'(c);
      if (!grant_any && rst_n && bus.req_valid[c_idx]) begin
        grant_any = 1'b1;
        grant_idx = c_idx;
      end
    end
  end

  assign sel_addr     = ch_addr[grant_idx];
  assign sel_wdata    = ch_wdata[grant_idx];
  assign sel_wmsk     = ch_wmsk[grant_idx];
  assign sel_we       = bus.req_we[grant_idx];
  // Addresses past SIZE (non-power-of-2 SIZE) must not corrupt anything.
  assign sel_in_range = (32'(sel_addr) < 32'(SIZE));

  // RAM port: read-first capture plus byte-lane write of unmasked lanes.
  always_ff @(posedge clk) begin
    if (grant_any) begin
      mem_rdata_reg <= mem[sel_addr];
      if (sel_we && sel_in_range) begin
        for (int b = 0; b < NB; b++) begin
          if (!sel_wmsk[b]) mem[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Arbitration pointer and first response stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg   <= '0;
      s1_oh_reg <= '0;
      seen_reg  <= 1'b0;
    end else begin
      s1_oh_reg <= grant_oh;
      if (grant_any) begin
        ptr_reg  <= (int'(grant_idx) == N_CH - 1) ? '0 : grant_idx + CW'(1);
        seen_reg <= 1'b1;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [N_CH-1:0] s2_oh_reg;
      logic [DW-1:0]   out_rdata_reg;

      // Extra output stage; data only moves when a response is in stage 1.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_oh_reg     <= '0;
          out_rdata_reg <= '0;
        end else begin
          s2_oh_reg <= s1_oh_reg;
          if (|s1_oh_reg) out_rdata_reg <= mem_rdata_reg;
        end
      end

      assign bus.rsp_valid = s2_oh_reg;
      assign bus.rsp_rdata = out_rdata_reg;
    end else begin : g_no_out_reg
      // The RAM read register has no reset, so it is masked until first use.
      assign bus.rsp_valid = s1_oh_reg;
      assign bus.rsp_rdata = seen_reg ? mem_rdata_reg : '0;
    end
  endgenerate
endmodule

// File: tb/tb_soc_bram_arb.sv
// Directed bench for soc_bram_arb: dut0 without, dut1 with output register.
module tb_soc_bram_arb;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  soc_bram_arb_if #(.N_CH(2), .AW(8), .DW(32)) bus0 ();
  soc_bram_arb_if #(.N_CH(2), .AW(8), .DW(32)) bus1 ();

  soc_bram_arb #(.SIZE(256), .DW(32), .N_CH(2), .OUT_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  soc_bram_arb #(.SIZE(256), .DW(32), .N_CH(2), .OUT_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  // Present one request on channel ch of dut d.
  task automatic put(input int d, input int ch, input logic we, input logic [7:0] a,
                     input logic [31:0] wd, input logic [3:0] m);
    if (d == 0) begin
      bus0.req_valid[ch] = 1'b1; bus0.req_we[ch] = we; bus0.req_addr[ch*8 +: 8] = a;
      bus0.req_wdata[ch*32 +: 32] = wd; bus0.req_wmsk[ch*4 +: 4] = m;
    end else begin
      bus1.req_valid[ch] = 1'b1; bus1.req_we[ch] = we; bus1.req_addr[ch*8 +: 8] = a;
      bus1.req_wdata[ch*32 +: 32] = wd; bus1.req_wmsk[ch*4 +: 4] = m;
    end
    $display("txn dut%0d ch%0d %s addr=%02h wdata=%08h wmsk=%04b", d, ch,
             we ? "WR" : "RD", a, wd, m);
  endtask

  task automatic idle_all();
    bus0.req_valid = '0;
    bus1.req_valid = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus0.req_addr = '0; bus0.req_wdata = '0; bus0.req_wmsk = '1; bus0.req_we = '0;
    bus1.req_addr = '0; bus1.req_wdata = '0; bus1.req_wmsk = '1; bus1.req_we = '0;
    idle_all();
    put(0, 0, 1'b0, 8'h00, 32'h0, 4'hF);
    put(0, 1, 1'b0, 8'h00, 32'h0, 4'hF);
    repeat (2) @(negedge clk);
    n_cmp++; if (bus0.rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rst_rsp_valid got=%b exp=00", bus0.rsp_valid); end
    n_cmp++; if (bus0.rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rsp_rdata got=%h exp=0", bus0.rsp_rdata); end
    n_cmp++; if (bus0.req_ready !== 2'b00) begin n_bad++; $display("FAIL rst_req_ready got=%b exp=00", bus0.req_ready); end
    n_cmp++; if (bus1.rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rsp_rdata_oreg got=%h exp=0", bus1.rsp_rdata); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus0.req_ready !== 2'b01) begin n_bad++; $display("FAIL rst_first_grant got=%b exp=01", bus0.req_ready); end
    @(negedge clk);
    idle_all();
    n_cmp++; if (bus0.rsp_valid !== 2'b01) begin n_bad++; $display("FAIL rst_first_rsp got=%b exp=01", bus0.rsp_valid); end
    @(negedge clk);
  endtask

  task automatic test_masked_write();
    put(0, 0, 1'b1, 8'h10, 32'hAABBCCDD, 4'b0000);
    #1;
    n_cmp++; if (bus0.req_ready !== 2'b01) begin n_bad++; $display("FAIL mw_ready got=%b exp=01", bus0.req_ready); end
    @(negedge clk);
    n_cmp++; if (bus0.rsp_valid !== 2'b01) begin n_bad++; $display("FAIL mw_wr1_valid got=%b exp=01", bus0.rsp_valid); end
    // Lanes 3 and 1 keep their old bytes, lanes 2 and 0 take new data.
    put(0, 0, 1'b1, 8'h10, 32'h11223344, 4'b1010);
    @(negedge clk);
    n_cmp++; if (bus0.rsp_valid !== 2'b01) begin n_bad++; $display("FAIL mw_wr2_valid got=%b exp=01", bus0.rsp_valid); end
    n_cmp++; if (bus0.rsp_rdata !== 32'hAABBCCDD) begin n_bad++; $display("FAIL mw_wr2_readfirst got=%h exp=aabbccdd", bus0.rsp_rdata); end
    put(0, 0, 1'b1, 8'h10, 32'hFFFFFFFF, 4'b1111);
    @(negedge clk);
    n_cmp++; if (bus0.rsp_valid !== 2'b01) begin n_bad++; $display("FAIL mw_nowr_valid got=%b exp=01", bus0.rsp_valid); end
    n_cmp++; if (bus0.rsp_rdata !== 32'hAA22CC44) begin n_bad++; $display("FAIL mw_nowr_rdata got=%h exp=aa22cc44", bus0.rsp_rdata); end
    put(0, 0, 1'b0, 8'h10, 32'h0, 4'hF);
    @(negedge clk);
    idle_all();
    n_cmp++; if (bus0.rsp_valid !== 2'b01) begin n_bad++; $display("FAIL mw_rd_valid got=%b exp=01", bus0.rsp_valid); end
    n_cmp++; if (bus0.rsp_rdata !== 32'hAA22CC44) begin n_bad++; $display("FAIL mw_rd_rdata got=%h exp=aa22cc44", bus0.rsp_rdata); end
    @(negedge clk);
    n_cmp++; if (bus0.rsp_valid !== 2'b00) begin n_bad++; $display("FAIL mw_strobe_width got=%b exp=00", bus0.rsp_valid); end
    n_cmp++; if (bus0.rsp_rdata !== 32'hAA22CC44) begin n_bad++; $display("FAIL mw_rdata_hold got=%h exp=aa22cc44", bus0.rsp_rdata); end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_rdy;
    logic [31:0] exp_data;
    put(0, 0, 1'b1, 8'h01, 32'h1, 4'b0000);
    @(negedge clk);
    idle_all();
    put(0, 1, 1'b1, 8'h02, 32'h2, 4'b0000);
    @(negedge clk);
    // Last grant went to ch1, so the search restarts at ch0.
    put(0, 0, 1'b0, 8'h01, 32'h0, 4'hF);
    put(0, 1, 1'b0, 8'h02, 32'h0, 4'hF);
    for (int k = 0; k < 6; k++) begin
      exp_rdy  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_data = (k % 2 == 0) ? 32'h1 : 32'h2;
      #1;
      n_cmp++; if (bus0.req_ready !== exp_rdy) begin n_bad++; $display("FAIL ct_ready[%0d] got=%b exp=%b", k, bus0.req_ready, exp_rdy); end
      @(negedge clk);
      n_cmp++; if (bus0.rsp_valid !== exp_rdy) begin n_bad++; $display("FAIL ct_rsp_valid[%0d] got=%b exp=%b", k, bus0.rsp_valid, exp_rdy); end
      n_cmp++; if (bus0.rsp_rdata !== exp_data) begin n_bad++; $display("FAIL ct_rsp_rdata[%0d] got=%h exp=%h", k, bus0.rsp_rdata, exp_data); end
    end
    idle_all();
    @(negedge clk);
  endtask

  task automatic test_hazard();
    put(0, 1, 1'b1, 8'h03, 32'hDEADBEEF, 4'b0000);
    #1;
    n_cmp++; if (bus0.req_ready !== 2'b10) begin n_bad++; $display("FAIL hz_wr_ready got=%b exp=10", bus0.req_ready); end
    @(negedge clk);
    idle_all();
    put(0, 0, 1'b0, 8'h03, 32'h0, 4'hF);
    #1;
    n_cmp++; if (bus0.req_ready !== 2'b01) begin n_bad++; $display("FAIL hz_rd_ready got=%b exp=01", bus0.req_ready); end
    n_cmp++; if (bus0.rsp_valid !== 2'b10) begin n_bad++; $display("FAIL hz_wr_rsp got=%b exp=10", bus0.rsp_valid); end
    @(negedge clk);
    idle_all();
    n_cmp++; if (bus0.rsp_valid !== 2'b01) begin n_bad++; $display("FAIL hz_rd_rsp got=%b exp=01", bus0.rsp_valid); end
    n_cmp++; if (bus0.rsp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL hz_rd_rdata got=%h exp=deadbeef", bus0.rsp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_out_reg();
    put(1, 0, 1'b1, 8'h05, 32'h55, 4'b0000);
    @(negedge clk);
    n_cmp++; if (bus1.rsp_valid !== 2'b00) begin n_bad++; $display("FAIL or_wr_early got=%b exp=00", bus1.rsp_valid); end
    put(1, 0, 1'b1, 8'h06, 32'h66, 4'b0000);
    @(negedge clk);
    idle_all();
    n_cmp++; if (bus1.rsp_valid !== 2'b01) begin n_bad++; $display("FAIL or_wr5_rsp got=%b exp=01", bus1.rsp_valid); end
    @(negedge clk);
    n_cmp++; if (bus1.rsp_valid !== 2'b01) begin n_bad++; $display("FAIL or_wr6_rsp got=%b exp=01", bus1.rsp_valid); end
    @(negedge clk);
    n_cmp++; if (bus1.rsp_valid !== 2'b00) begin n_bad++; $display("FAIL or_flush got=%b exp=00", bus1.rsp_valid); end
    put(1, 0, 1'b0, 8'h05, 32'h0, 4'hF);
    #1;
    n_cmp++; if (bus1.req_ready !== 2'b01) begin n_bad++; $display("FAIL or_rd_ready got=%b exp=01", bus1.req_ready); end
    @(negedge clk);
    idle_all();
    n_cmp++; if (bus1.rsp_valid !== 2'b00) begin n_bad++; $display("FAIL or_rd_lat1 got=%b exp=00", bus1.rsp_valid); end
    @(negedge clk);
    n_cmp++; if (bus1.rsp_valid !== 2'b01) begin n_bad++; $display("FAIL or_rd_lat2 got=%b exp=01", bus1.rsp_valid); end
    n_cmp++; if (bus1.rsp_rdata !== 32'h55) begin n_bad++; $display("FAIL or_rd_rdata got=%h exp=55", bus1.rsp_rdata); end
    @(negedge clk);
    n_cmp++; if (bus1.rsp_valid !== 2'b00) begin n_bad++; $display("FAIL or_strobe_width got=%b exp=00", bus1.rsp_valid); end
    n_cmp++; if (bus1.rsp_rdata !== 32'h55) begin n_bad++; $display("FAIL or_rdata_hold got=%h exp=55", bus1.rsp_rdata); end
    put(1, 0, 1'b0, 8'h05, 32'h0, 4'hF);
    @(negedge clk);
    put(1, 0, 1'b0, 8'h06, 32'h0, 4'hF);
    n_cmp++; if (bus1.rsp_valid !== 2'b00) begin n_bad++; $display("FAIL or_b2b_early got=%b exp=00", bus1.rsp_valid); end
    @(negedge clk);
    idle_all();
    n_cmp++; if (bus1.rsp_valid !== 2'b01 || bus1.rsp_rdata !== 32'h55) begin n_bad++; $display("FAIL or_b2b_first got=%b/%h exp=01/55", bus1.rsp_valid, bus1.rsp_rdata); end
    @(negedge clk);
    n_cmp++; if (bus1.rsp_valid !== 2'b01 || bus1.rsp_rdata !== 32'h66) begin n_bad++; $display("FAIL or_b2b_second got=%b/%h exp=01/66", bus1.rsp_valid, bus1.rsp_rdata); end
    @(negedge clk);
    n_cmp++; if (bus1.rsp_valid !== 2'b00) begin n_bad++; $display("FAIL or_b2b_end got=%b exp=00", bus1.rsp_valid); end
  endtask

  task automatic test_reset_midflight();
    put(1, 0, 1'b1, 8'h07, 32'h77, 4'b0000);
    @(negedge clk);
    put(1, 0, 1'b0, 8'h05, 32'h0, 4'hF);
    @(negedge clk);
    // Read is in the pipeline now; kill it.
    idle_all();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus1.rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rm_in_reset_valid got=%b exp=00", bus1.rsp_valid); end
    n_cmp++; if (bus1.rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL rm_in_reset_rdata got=%h exp=0", bus1.rsp_rdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (bus1.rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rm_no_rsp[%0d] got=%b exp=00", k, bus1.rsp_valid); end
    end
    put(1, 0, 1'b0, 8'h07, 32'h0, 4'hF);
    #1;
    n_cmp++; if (bus1.req_ready !== 2'b01) begin n_bad++; $display("FAIL rm_rd_ready got=%b exp=01", bus1.req_ready); end
    @(negedge clk);
    idle_all();
    @(negedge clk);
    n_cmp++; if (bus1.rsp_valid !== 2'b01) begin n_bad++; $display("FAIL rm_rd_valid got=%b exp=01", bus1.rsp_valid); end
    n_cmp++; if (bus1.rsp_rdata !== 32'h77) begin n_bad++; $display("FAIL rm_rd_rdata got=%h exp=77", bus1.rsp_rdata); end
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_contention();
    test_hazard();
    test_out_reg();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
